// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port, one transaction
// in flight, round-robin on ties, with a per-transaction response timeout.
//
// state | meaning
// IDLE  | pick a winner, accept one request
// REQ   | drive the latched request to memory until mem_req_ready
// WAIT  | request issued, waiting for mem_resp_valid
// RESP  | one-cycle response pulse to the owner
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic        owner_lsu, last_lsu;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        wen_q, err_q;
    logic [3:0]  wmask_q;
    logic [7:0]  cnt, cnt_inc;
    logic        grant_ifu, grant_lsu, accept_ifu, accept_lsu;
    logic        capture, tmo_hit, active;

    always_comb begin
        grant_ifu  = ifu_req_valid && (!lsu_req_valid || last_lsu);
        grant_lsu  = lsu_req_valid && (!ifu_req_valid || !last_lsu);
        accept_ifu = (state == IDLE) && grant_ifu;
        accept_lsu = (state == IDLE) && grant_lsu;
        active     = (state == REQ) || (state == WAIT);
        // cnt_inc counts the current cycle, so the timeout fires in the TIMEOUT-th REQ/WAIT cycle
        cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        tmo_hit    = active && (cnt_inc == TMO);
        capture    = ((state == REQ) && mem_req_ready && mem_resp_valid) ||
                     ((state == WAIT) && mem_resp_valid);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_ifu || accept_lsu) state_nxt = REQ;
            REQ: begin
                if (capture || tmo_hit) state_nxt = RESP;
                else if (mem_req_ready) state_nxt = WAIT;
            end
            WAIT: if (capture || tmo_hit) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            wen_q     <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (accept_ifu) begin
                addr_q    <= ifu_addr;
                wen_q     <= 1'b0;
                wdata_q   <= '0;
                wmask_q   <= 4'b0000;
                owner_lsu <= 1'b0;
                last_lsu  <= 1'b0;
                cnt       <= '0;
            end else if (accept_lsu) begin
                addr_q    <= lsu_addr;
                wen_q     <= lsu_wen;
                wdata_q   <= lsu_wdata;
                wmask_q   <= lsu_wmask;
                owner_lsu <= 1'b1;
                last_lsu  <= 1'b1;
                cnt       <= '0;
            end else if (active) begin
                cnt <= cnt_inc;
            end
            // a response arriving in the timeout cycle still counts as a good response
            if (capture) begin
                rdata_q <= mem_rdata;
                err_q   <= 1'b0;
            end else if (tmo_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_resp_err   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    ifu_req_ready = grant_ifu;
                    lsu_req_ready = grant_lsu;
                end
                REQ: begin
                    mem_req_valid = 1'b1;
                    mem_addr      = addr_q;
                    mem_wen       = wen_q;
                    mem_wdata     = wdata_q;
                    mem_wmask     = wmask_q;
                end
                RESP: begin
                    if (owner_lsu) begin
                        lsu_resp_valid = 1'b1;
                        lsu_rdata      = rdata_q;
                        lsu_resp_err   = err_q;
                    end else begin
                        ifu_resp_valid = 1'b1;
                        ifu_rdata      = rdata_q;
                        ifu_resp_err   = err_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter built with TIMEOUT=4: tie rotation, zero-wait read,
// stalled write, timeout, stray responses and reset mid-transaction.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 ns after the rising edge; checks happen 1 ns later still
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = '0;
        lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        #2;
        chk("rst_ifu_ready", ifu_req_ready, 0);
        chk("rst_lsu_ready", lsu_req_ready, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        tick(); tick();

        // tie rotation from reset: IFU, LSU, IFU, LSU
        rst = 1'b0;
        ifu_addr = 32'h0000_1000; lsu_addr = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_ifu_ready", ifu_req_ready, (i % 2 == 0));
            chk("tie_lsu_ready", lsu_req_ready, (i % 2 == 1));
            tick();
            mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hA000_0000 + i;
            #1;
            chk("tie_mem_addr", mem_addr, (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            chk("tie_busy_ready", {ifu_req_ready, lsu_req_ready}, 0);
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            #1;
            chk("tie_ifu_resp", ifu_resp_valid, (i % 2 == 0));
            chk("tie_lsu_resp", lsu_resp_valid, (i % 2 == 1));
            chk("tie_rdata", (i % 2 == 0) ? ifu_rdata : lsu_rdata, 32'hA000_0000 + i);
            tick();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // IFU-only zero-wait read
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        chk("rd_ifu_ready", ifu_req_ready, 1);
        chk("rd_lsu_ready", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("rd_mem_valid", mem_req_valid, 1);
        chk("rd_mem_addr", mem_addr, 32'h8000_0000);
        chk("rd_mem_wen", mem_wen, 0);
        chk("rd_mem_wmask", mem_wmask, 0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk("rd_ifu_resp", ifu_resp_valid, 1);
        chk("rd_ifu_rdata", ifu_rdata, 32'h1234_5678);
        chk("rd_ifu_err", ifu_resp_err, 0);
        chk("rd_lsu_resp", lsu_resp_valid, 0);
        tick();
        chk("rd_resp_gone", ifu_resp_valid, 0);

        // LSU write, 3 stall cycles; response lands in the 4th REQ cycle alongside the timeout
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        #1;
        chk("wr_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0; lsu_wdata = '0; lsu_addr = '0; lsu_wmask = '0; lsu_wen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
            end
            #1;
            chk("wr_mem_valid", mem_req_valid, 1);
            chk("wr_mem_addr", mem_addr, 32'h8000_1000);
            chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("wr_mem_wmask", mem_wmask, 4'b0011);
            chk("wr_mem_wen", mem_wen, 1);
            chk("wr_no_resp", lsu_resp_valid, 0);
            tick();
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk("wr_lsu_resp", lsu_resp_valid, 1);
        chk("wr_lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
        chk("wr_lsu_err", lsu_resp_err, 0);
        tick();

        // LSU read that never gets a response: error 5 cycles after accept
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
        #1;
        chk("to_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("to_mem_valid", mem_req_valid, 1);
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("to_wait_valid", mem_req_valid, 0);
        chk("to_wait_addr", mem_addr, 0);
        tick();
        #1;
        chk("to_c3_resp", lsu_resp_valid, 0);
        tick();
        #1;
        chk("to_c4_resp", lsu_resp_valid, 0);
        tick();
        #1;
        chk("to_c5_resp", lsu_resp_valid, 1);
        chk("to_c5_err", lsu_resp_err, 1);
        chk("to_c5_rdata", lsu_rdata, 0);
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("stray_lsu_resp", lsu_resp_valid, 0);
        chk("stray_ifu_resp", ifu_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("stray_after", {ifu_resp_valid, lsu_resp_valid}, 0);

        // IFU read abandoned by reset in WAIT
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_3000;
        #1;
        chk("rw_ifu_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        chk("rw_rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("rw_rst_mem", mem_req_valid, 0);
        chk("rw_rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        tick();
        rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
        #1;
        chk("rw_late_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rw_tie_ifu", ifu_req_ready, 1);
        chk("rw_tie_lsu", lsu_req_ready, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("rw_next_addr", mem_addr, 32'h8000_3000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
